// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix double-buffered framebuffer:
// panel geometry, pixel type, controller states and an address helper.
package matrix_pkg;

   localparam int COLS      = 32;
   localparam int HALF_ROWS = 16;
   localparam int FB_DEPTH  = COLS * HALF_ROWS * 2;
   localparam int FB_ADDR_W = $clog2(FB_DEPTH);

   typedef logic [2:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      PEND  = 2'd2
   } fb_state_t;

   // Linear buffer address of pixel (x, y), row-major.
   function automatic logic [FB_ADDR_W-1:0] pixel_addr(input logic [4:0] x, input logic [4:0] y);
      return FB_ADDR_W'(y) * FB_ADDR_W'(COLS) + FB_ADDR_W'(x);
   endfunction

endpackage

// File: rtl/matrix_framebuf_if.sv
// Host/driver-side bundle of the framebuffer: write port, buffer control
// handshake and the scan outputs towards the matrix driver.
interface matrix_framebuf_if;
   import matrix_pkg::*;

   logic       enable;
   logic       wr_en;
   logic [4:0] wr_x;
   logic [4:0] wr_y;
   pixel_t     wr_rgb;
   logic       clear;
   logic       swap_req;
   logic       busy;
   logic       swap_ack;
   pixel_t     RGB1bus;
   pixel_t     RGB2bus;
   logic       frame_start;

   modport master (
      output enable, wr_en, wr_x, wr_y, wr_rgb, clear, swap_req,
      input  busy, swap_ack, RGB1bus, RGB2bus, frame_start
   );

   modport slave (
      input  enable, wr_en, wr_x, wr_y, wr_rgb, clear, swap_req,
      output busy, swap_ack, RGB1bus, RGB2bus, frame_start
   );

endinterface

// File: rtl/fb_ram.sv
// One frame buffer: single write port plus two synchronous read ports that
// share a read strobe, so the top and bottom panel halves are fetched together.
module fb_ram import matrix_pkg::*; #(
   parameter int DEPTH  = FB_DEPTH,
   parameter int ADDR_W = FB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  pixel_t            wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr_a,
   output pixel_t            rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output pixel_t            rdata_b
);

   pixel_t mem [DEPTH];

   // Storage is never reset so an image survives a controller reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read registers reset to black and hold their value between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else if (re) begin
         rdata_a <= mem[raddr_a];
         rdata_b <= mem[raddr_b];
      end
   end

endmodule

// File: rtl/matrix_framebuf.sv
// Double-buffered framebuffer for a two-half scanned LED matrix. The front
// buffer is scanned in step with the driver; the back buffer takes host
// writes and bulk clears; swaps are deferred to the end of a frame.
module matrix_framebuf import matrix_pkg::*; #(
   parameter int COLS      = matrix_pkg::COLS,
   parameter int HALF_ROWS = matrix_pkg::HALF_ROWS
) (
   input  logic clk,
   input  logic reset,
   matrix_framebuf_if.slave fb
);

   localparam int COL_W  = $clog2(COLS);
   localparam int ROW_W  = $clog2(HALF_ROWS);
   localparam int DEPTH  = COLS * HALF_ROWS * 2;
   localparam int ADDR_W = $clog2(DEPTH);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HALF_ROWS - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] HALF_OFS  = ADDR_W'(HALF_ROWS * COLS);

   fb_state_t state, next_state;

   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              sel;
   logic              rd_sel;
   logic [ADDR_W-1:0] clr_addr;

   logic              at_frame_end;
   logic              swap_fire;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   pixel_t            ram_wdata;
   logic              we0, we1;

   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr_top, rd_addr_bot;
   pixel_t            top0, bot0, top1, bot1;

   assign wr_addr      = ADDR_W'(fb.wr_y) * ADDR_W'(COLS) + ADDR_W'(fb.wr_x);
   assign rd_addr_top  = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   assign rd_addr_bot  = rd_addr_top + HALF_OFS;
   assign at_frame_end = fb.enable && (col == COL_LAST) && (row == ROW_LAST);

   // Controller state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Clear wins over swap, swap wins over write; requests are only seen in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (fb.clear) begin
               next_state = CLEAR;
            end else if (fb.swap_req) begin
               next_state = PEND;
            end
         end
         CLEAR: begin
            if (clr_addr == ADDR_LAST) begin
               next_state = IDLE;
            end
         end
         PEND: begin
            if (at_frame_end) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Back-buffer write port and swap trigger, decoded from the current state.
   always_comb begin
      fb.busy   = 1'b0;
      ram_we    = 1'b0;
      ram_waddr = wr_addr;
      ram_wdata = fb.wr_rgb;
      swap_fire = 1'b0;
      case (state)
         IDLE: begin
            ram_we = fb.wr_en && !fb.clear && !fb.swap_req;
         end
         CLEAR: begin
            fb.busy   = 1'b1;
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
         end
         PEND: begin
            fb.busy   = 1'b1;
            swap_fire = at_frame_end;
         end
         default: ;
      endcase
   end

   // Only the back buffer (the one not selected by sel) is ever written.
   assign we0 = ram_we && !reset && sel;
   assign we1 = ram_we && !reset && !sel;

   // Scan position follows the driver's pixel strobe; frame_start marks pixel (0,0).
   always_ff @(posedge clk) begin
      if (reset) begin
         col            <= '0;
         row            <= '0;
         fb.frame_start <= 1'b0;
      end else begin
         fb.frame_start <= fb.enable && (col == '0) && (row == '0);
         if (fb.enable) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Buffer ownership: rd_sel remembers which buffer the latest fetch came
   // from, so the last pixel of the old frame still shows after sel flips.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel         <= 1'b0;
         rd_sel      <= 1'b0;
         fb.swap_ack <= 1'b0;
      end else begin
         fb.swap_ack <= swap_fire;
         if (swap_fire) begin
            sel <= ~sel;
         end
         if (fb.enable) begin
            rd_sel <= sel;
         end
      end
   end

   // Clear sweep address: parked at zero outside CLEAR, one step per clock inside.
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_addr <= '0;
      end else if (state == CLEAR) begin
         clr_addr <= clr_addr + 1'b1;
      end else begin
         clr_addr <= '0;
      end
   end

   fb_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf0 (
      .clk     (clk),
      .reset   (reset),
      .we      (we0),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .re      (fb.enable),
      .raddr_a (rd_addr_top),
      .rdata_a (top0),
      .raddr_b (rd_addr_bot),
      .rdata_b (bot0)
   );

   fb_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf1 (
      .clk     (clk),
      .reset   (reset),
      .we      (we1),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .re      (fb.enable),
      .raddr_a (rd_addr_top),
      .rdata_a (top1),
      .raddr_b (rd_addr_bot),
      .rdata_b (bot1)
   );

   assign fb.RGB1bus = rd_sel ? top1 : top0;
   assign fb.RGB2bus = rd_sel ? bot1 : bot0;

endmodule

// File: tb/tb_matrix_framebuf.sv
// Self-checking bench for matrix_framebuf: a frame-level model (two pixel
// arrays, a scan position and a pending-operation flag) predicts every output
// each cycle, with directed scenarios plus a randomized soak.
module tb_matrix_framebuf;

   localparam int NCOLS  = 32;
   localparam int NHALF  = 16;
   localparam int NPIX   = 1024;
   localparam int M_IDLE = 0;
   localparam int M_CLR  = 1;
   localparam int M_PEND = 2;

   logic clk = 1'b0;
   logic reset;

   matrix_framebuf_if fbIf();

   matrix_framebuf #(.COLS(NCOLS), .HALF_ROWS(NHALF)) dut (
      .clk   (clk),
      .reset (reset),
      .fb    (fbIf)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   logic [2:0] mdlBuf   [2][NPIX];
   bit         mdlKnown [2][NPIX];
   int         mdlSel, mdlCol, mdlRow, mdlMode, mdlClearLeft;
   logic [2:0] expRgb1, expRgb2;
   bit         expValid1, expValid2;
   bit         expBusy, expAck, expFs;

   int vectorCount     = 0;
   int miscompareCount = 0;

   task automatic compare(input string name, input int actual, input int expected);
      vectorCount++;
      if (actual != expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit chance(input int permil);
      return $urandom_range(0, 999) < permil;
   endfunction

   // Frame-level prediction of one clock edge from the inputs present at it.
   task automatic modelStep();
      int back, idx, topIdx, botIdx;
      if (reset) begin
         mdlSel = 0; mdlCol = 0; mdlRow = 0; mdlMode = M_IDLE;
         expRgb1 = 3'd0; expRgb2 = 3'd0; expValid1 = 1; expValid2 = 1;
         expBusy = 0; expAck = 0; expFs = 0;
         return;
      end
      back  = 1 - mdlSel;
      expFs = fbIf.enable && mdlCol == 0 && mdlRow == 0;
      expAck = 0;
      if (fbIf.enable) begin
         topIdx    = mdlRow * NCOLS + mdlCol;
         botIdx    = (mdlRow + NHALF) * NCOLS + mdlCol;
         expRgb1   = mdlBuf[mdlSel][topIdx];
         expValid1 = mdlKnown[mdlSel][topIdx];
         expRgb2   = mdlBuf[mdlSel][botIdx];
         expValid2 = mdlKnown[mdlSel][botIdx];
      end
      case (mdlMode)
         M_IDLE: begin
            if (fbIf.clear) begin
               mdlMode = M_CLR;
               mdlClearLeft = NPIX;
            end else if (fbIf.swap_req) begin
               mdlMode = M_PEND;
            end else if (fbIf.wr_en) begin
               idx = int'(fbIf.wr_y) * NCOLS + int'(fbIf.wr_x);
               mdlBuf[back][idx]   = fbIf.wr_rgb;
               mdlKnown[back][idx] = 1;
            end
         end
         M_CLR: begin
            idx = NPIX - mdlClearLeft;
            mdlBuf[back][idx]   = 3'd0;
            mdlKnown[back][idx] = 1;
            mdlClearLeft--;
            if (mdlClearLeft == 0) mdlMode = M_IDLE;
         end
         default: begin
            if (fbIf.enable && mdlCol == NCOLS - 1 && mdlRow == NHALF - 1) begin
               mdlSel  = back;
               expAck  = 1;
               mdlMode = M_IDLE;
            end
         end
      endcase
      if (fbIf.enable) begin
         mdlCol++;
         if (mdlCol == NCOLS) begin
            mdlCol = 0;
            mdlRow = (mdlRow + 1) % NHALF;
         end
      end
      expBusy = (mdlMode != M_IDLE);
   endtask

   task automatic checkOutput();
      if (expValid1) compare("RGB1bus", int'(fbIf.RGB1bus), int'(expRgb1));
      if (expValid2) compare("RGB2bus", int'(fbIf.RGB2bus), int'(expRgb2));
      compare("busy",        int'(fbIf.busy),        int'(expBusy));
      compare("swap_ack",    int'(fbIf.swap_ack),    int'(expAck));
      compare("frame_start", int'(fbIf.frame_start), int'(expFs));
   endtask

   // Drive one cycle of inputs at the falling edge, predict, then check.
   task automatic applyStimulus(input bit rst, input bit en, input bit we, input int x, input int y,
                                input int rgb, input bit clr, input bit swp);
      reset         = rst;
      fbIf.enable   = en;
      fbIf.wr_en    = we;
      fbIf.wr_x     = 5'(x);
      fbIf.wr_y     = 5'(y);
      fbIf.wr_rgb   = 3'(rgb);
      fbIf.clear    = clr;
      fbIf.swap_req = swp;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idleCycle(input bit en);
      applyStimulus(0, en, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic waitNotBusy(input string tag);
      int n = 0;
      while (fbIf.busy && n < 1100) begin
         idleCycle(chance(700));
         n++;
      end
      compare({tag, "_busy_timeout"}, int'(fbIf.busy), 0);
   endtask

   task automatic doSwap(input string tag, output int enables);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      enables = 0;
      while (!fbIf.swap_ack && enables < 600) begin
         idleCycle(1);
         enables++;
      end
      compare({tag, "_ack_timeout"}, int'(fbIf.swap_ack), 1);
   endtask

   task automatic randomWrites(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, chance(500), 1, $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 7), 0, 0);
      end
   endtask

   // Global time limit so a stuck design still ends the run.
   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int enables, busyCycles, nonZero, fsCount, ackCount;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < NPIX; i++) mdlKnown[b][i] = 0;
      end
      reset = 1;
      fbIf.enable = 0; fbIf.wr_en = 0; fbIf.wr_x = 0; fbIf.wr_y = 0;
      fbIf.wr_rgb = 0; fbIf.clear = 0; fbIf.swap_req = 0;
      @(negedge clk);

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 3, 3, 7, 1, 1);
      compare("reset_RGB1bus",     int'(fbIf.RGB1bus), 0);
      compare("reset_RGB2bus",     int'(fbIf.RGB2bus), 0);
      compare("reset_busy",        int'(fbIf.busy), 0);
      compare("reset_swap_ack",    int'(fbIf.swap_ack), 0);
      compare("reset_frame_start", int'(fbIf.frame_start), 0);

      // Bring both buffers to a known all-black image, then paint buffer 0.
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
      waitNotBusy("init_clear1");
      doSwap("init_swap", enables);
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
      waitNotBusy("init_clear2");
      randomWrites(300);
      applyStimulus(0, 0, 1, 0, 1, 6, 0, 0);
      applyStimulus(0, 0, 1, 0, 17, 3, 0, 0);

      // Reset shows buffer 0; 33 strobes reach pixel (col 0, row 1).
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 33; i++) begin
         idleCycle(1);
         if (i == 1) compare("scan_frame_start_first", int'(fbIf.frame_start), 1);
         if (i == 2) compare("scan_frame_start_second", int'(fbIf.frame_start), 0);
      end
      compare("scan_row1_top", int'(fbIf.RGB1bus), 6);
      compare("scan_row17_bot", int'(fbIf.RGB2bus), 3);

      // Write into the back buffer then swap; the swap waits for frame end.
      applyStimulus(0, 0, 1, 5, 20, 5, 0, 0);
      doSwap("swap", enables);
      compare("swap_enables_to_ack", enables, 479);
      for (int i = 1; i <= 134; i++) begin
         idleCycle(1);
         if (i == 1) compare("swap_frame_start", int'(fbIf.frame_start), 1);
      end
      compare("swap_pixel_bot", int'(fbIf.RGB2bus), 5);
      compare("swap_pixel_top", int'(fbIf.RGB1bus), 0);

      // Clear with writes hammering the port for its whole duration.
      busyCycles = 0;
      applyStimulus(0, chance(500), 0, 0, 0, 0, 1, 0);
      if (fbIf.busy) busyCycles++;
      for (int i = 0; i < 1024; i++) begin
         applyStimulus(0, chance(500), 1, $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(1, 7), 0, 0);
         if (fbIf.busy) busyCycles++;
      end
      compare("clear_busy_cycles", busyCycles, 1024);
      compare("clear_done_busy", int'(fbIf.busy), 0);
      doSwap("clear_swap", enables);
      nonZero = 0;
      for (int i = 0; i < 512; i++) begin
         idleCycle(1);
         if (fbIf.RGB1bus != 3'd0 || fbIf.RGB2bus != 3'd0) nonZero++;
      end
      compare("clear_frame_nonzero", nonZero, 0);

      // Simultaneous clear, swap and write: clear alone proceeds.
      applyStimulus(0, 1, 1, 3, 3, 7, 1, 1);
      compare("prec_busy", int'(fbIf.busy), 1);
      ackCount = 0;
      for (int i = 0; i < 1030; i++) begin
         idleCycle(1);
         if (fbIf.swap_ack) ackCount++;
      end
      compare("prec_no_swap", ackCount, 0);
      compare("prec_idle", int'(fbIf.busy), 0);

      // Reset while a swap is pending aborts it.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      doSwap("pend_dummy_skip", enables);
      randomWrites(100);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 50; i++) idleCycle(1);
      compare("pend_busy", int'(fbIf.busy), 1);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
      compare("pend_reset_ack", int'(fbIf.swap_ack), 0);
      compare("pend_reset_busy", int'(fbIf.busy), 0);
      for (int i = 0; i < 40; i++) idleCycle(1);

      // Strobe held low: outputs freeze and no frame marker appears.
      fsCount = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(0, 0, chance(500), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 7), 0, 0);
         if (fbIf.frame_start) fsCount++;
      end
      compare("hold_frame_start", fsCount, 0);

      // Randomized soak.
      for (int i = 0; i < 15000; i++) begin
         applyStimulus(chance(1), chance(750), chance(500), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 7), chance(3), chance(25));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule

// File: doc/matrix_framebuf.md
MATRIX_FRAMEBUF -- requirements
Module: matrix_framebuf

Interface
REQ-001 SHALL have parameter COLS, default 32, panel columns per row.
REQ-002 SHALL have parameter HALF_ROWS, default 16, rows per panel half (rows scanned per frame).
REQ-003 SHALL have port clk  in  1  rising-edge clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  in  1  pixel-advance strobe, same strobe that drives the matrix driver's column counter.
REQ-006 SHALL have port wr_en  in  1  write strobe into back buffer.
REQ-007 SHALL have port wr_x  in  5  write column 0..31.
REQ-008 SHALL have port wr_y  in  5  write row 0..31; rows 0..15 are the top half, rows 16..31 are the bottom half.
REQ-009 SHALL have port wr_rgb  in  3  pixel {R,G,B}.
REQ-010 SHALL have port clear  in  1  one-cycle request to zero the back buffer.
REQ-011 SHALL have port swap_req  in  1  one-cycle request to exchange front and back buffers.
REQ-012 SHALL have port busy  out  1  high while in CLEAR or PEND.
REQ-013 SHALL have port swap_ack  out  1  one-cycle pulse on the cycle a swap takes effect.
REQ-014 SHALL have port RGB1bus  out  3  top-half pixel {R,G,B} to the driver.
REQ-015 SHALL have port RGB2bus  out  3  bottom-half pixel {R,G,B} to the driver.
REQ-016 SHALL have port frame_start  out  1  one-cycle pulse when pixel (col 0, row 0) is loaded.

Function
REQ-017 SHALL hold two 32x32x3 buffers; front buffer is read for display, back buffer is written; a 1-bit sel register identifies the front buffer.
REQ-018 SHALL keep scan counters col (5b) and row (4b); on each cycle with enable=1, col increments, and when col wraps 31->0, row increments (15->0 wraps).
REQ-019 SHALL, on each enable=1 cycle, register RGB1bus<=front[row][col] and RGB2bus<=front[row+16][col]; latency is one clock; outputs SHALL hold when enable=0.
REQ-020 SHALL assert frame_start for exactly the cycle after an enable=1 cycle with col=0, row=0.
REQ-021 SHALL use FSM states IDLE, CLEAR, PEND.
REQ-022 SHALL, in IDLE with wr_en=1, write wr_rgb to back[wr_y][wr_x] in one cycle.
REQ-023 SHALL, in IDLE with clear=1, go to CLEAR; CLEAR SHALL write 0 to one back-buffer address per clock, addresses 0..1023, then return to IDLE (1024 cycles, independent of enable).
REQ-024 SHALL, in IDLE with swap_req=1, go to PEND.
REQ-025 SHALL, in PEND, on the first enable=1 cycle with col=31 and row=15, toggle sel, pulse swap_ack, and return to IDLE; the next displayed pixel (0,0) SHALL come from the new front buffer.
REQ-026 SHALL give precedence clear > swap_req > wr_en when these are asserted together in IDLE; the losing requests SHALL be dropped.
REQ-027 SHALL ignore wr_en, clear and swap_req while busy=1.
REQ-028 SHALL never let writes or clears touch the front buffer; scan output SHALL be unaffected by back-buffer activity.

Reset
REQ-029 SHALL, on reset, set col=0, row=0, sel=0, state=IDLE, RGB1bus=0, RGB2bus=0, busy=0, swap_ack=0, frame_start=0.
REQ-030 SHALL NOT clear buffer contents on reset; reset during CLEAR or PEND SHALL abort the operation without a swap.

Structure
REQ-031 SHALL take COLS, HALF_ROWS, the pixel_t (3-bit) typedef and the fb_state_t enum from shared package matrix_pkg.
REQ-032 SHALL instantiate sub-module fb_ram (1024x3, one write port, two synchronous read ports) once per buffer.

Verification
REQ-033 SHALL test: reset, then 32 enable pulses -> col=0, row=1; RGB outputs equal front rows 0/16 in order, with one-clock latency.
REQ-034 SHALL test: write (x=5, y=20, rgb=3'b101) then swap_req -> swap_ack only after col=31, row=15 with enable; in the next frame, at col 5 of row 4, RGB2bus=3'b101.
REQ-035 SHALL test: clear, then wr_en on each of the next 1024 cycles -> busy=1 for exactly 1024 cycles; writes ignored; back buffer all zero.
REQ-036 SHALL test: clear, swap_req and wr_en asserted in the same cycle -> CLEAR entered; no swap; no write.
REQ-037 SHALL test: reset asserted in PEND -> no swap_ack; sel=0; busy=0 on the next cycle.
REQ-038 SHALL test: enable held low for 100 cycles -> RGB outputs, col and row are stable; no frame_start.
